seg7_scan_ctrl: RTL and testbench

// - Time-multiplexed scan controller for the 8-digit seven-segment display.
// - Holds a 32-bit display value (8 hex nibbles) and steps sel 0..7 at a fixed refresh rate.
// - Presents num/sel to the existing hex-to-7seg/anode decoder; blank forces anodes off downstream.
// - Double-buffered load: new values take effect only at frame boundaries (no tearing).

---
 rtl/seg7_scan_ctrl.sv | 194 +++++++++++++++++++
 tb/tb_seg7_scan_ctrl.sv | 380 ++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// seg7_scan_ctrl
//
// Time-multiplexed scan controller for an 8-digit seven-segment display.
// It holds a 32-bit display value (eight hex nibbles) and steps a digit
// index through 0..7. Each digit is shown for REFRESH_DIV clock cycles. The
// controller does not drive segments or anodes itself. It presents the digit
// index (sel), the nibble for that digit (num) and a blank flag to the
// existing hex-to-7seg / anode decoder.
//
// Loads are double-buffered so that a frame never shows a mix of old and
// new digits:
//   - While the display is off (S_OFF), the first accepted value goes
//     straight into the active register and scanning starts.
//   - While scanning (S_SCAN), an accepted value is parked in a shadow
//     register. It is promoted to active on the edge where sel wraps
//     7 -> 0, so digit 0 of the next frame is the first digit to show it.
//
// Ports
//   clk         in   1    system clock, all logic on the rising edge
//   rst_n       in   1    synchronous reset, active-low
//   ld_valid    in   1    load request; ld_data is valid
//   ld_data     in   32   display value, nibble k -> digit k (digit 0 = [3:0])
//   ld_ready    out  1    a load can be accepted this cycle (= no load pending)
//   digit_en    in   8    per-digit enable mask, used live (not latched)
//   lz_blank    in   1    1 = suppress leading zeros (digit 0 always lit)
//   sel         out  3    digit index for the decoder / anode select
//   num         out  4    nibble for digit sel
//   blank       out  1    1 = current digit dark
//   frame_done  out  1    one-cycle pulse during the last cycle of digit 7
//
// Parameters
//   REFRESH_DIV  clock cycles each digit is shown (must be >= 2)
// ---------------------------------------------------------------------------
module seg7_scan_ctrl #(
    parameter int REFRESH_DIV = 100000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ld_valid,
    input  logic [31:0] ld_data,
    output logic        ld_ready,
    input  logic [7:0]  digit_en,
    input  logic        lz_blank,
    output logic [2:0]  sel,
    output logic [3:0]  num,
    output logic        blank,
    output logic        frame_done
);

    // -----------------------------------------------------------------------
    // Constants
    // -----------------------------------------------------------------------
    localparam int CNT_W = $clog2(REFRESH_DIV);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [2:0]       SEL_LAST = 3'd7;

    localparam logic [0:0] S_OFF  = 1'b0;
    localparam logic [0:0] S_SCAN = 1'b1;

    // -----------------------------------------------------------------------
    // State registers and their next-state values
    // -----------------------------------------------------------------------
    logic [0:0]       state_reg,   state_next;
    logic [CNT_W-1:0] cnt_reg,     cnt_next;
    logic [2:0]       sel_reg,     sel_next;
    logic [31:0]      active_reg,  active_next;
    logic [31:0]      shadow_reg,  shadow_next;
    logic             pending_reg, pending_next;

    // -----------------------------------------------------------------------
    // Decoded control
    // -----------------------------------------------------------------------
    logic xfer;        // handshake completes at the coming edge
    logic tick;        // last cycle of the current digit period
    logic frame_end;   // last cycle of the digit-7 period

    // A single load can be outstanding. Once the shadow holds an
    // unpromoted value, further requests wait until the frame boundary.
    assign ld_ready  = !pending_reg;
    assign xfer      = ld_valid && ld_ready;

    assign tick      = (state_reg == S_SCAN) && (cnt_reg == CNT_LAST);
    assign frame_end = tick && (sel_reg == SEL_LAST);

    // -----------------------------------------------------------------------
    // Per-digit views of the active value
    //
    // nibble[k] is the value for digit k. upper_zero[k] is set when digits
    // k..7 are all zero, which is exactly the leading-zero condition for
    // digit k. Each upper_zero bit is taken directly from active_reg.
    // -----------------------------------------------------------------------
    logic [3:0] nibble [8];
    logic [7:0] upper_zero;

    generate
        for (genvar gi = 0; gi < 8; gi++) begin : g_digit
            assign nibble[gi]     = active_reg[4*gi +: 4];
            assign upper_zero[gi] = ~|active_reg[31:4*gi];
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Next-state logic
    // -----------------------------------------------------------------------
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        sel_next     = sel_reg;
        active_next  = active_reg;
        shadow_next  = shadow_reg;
        pending_next = pending_reg;

        if (state_reg == S_OFF) begin
            // The display is dark. The scan position stays at the start of
            // a frame, so the first digit-0 period is a full REFRESH_DIV
            // cycles long.
            cnt_next = '0;
            sel_next = '0;
            // Nothing is on screen, so the first load cannot tear. It goes
            // straight to active without waiting for a frame boundary.
            if (xfer) begin
                active_next = ld_data;
                state_next  = S_SCAN;
            end
        end else begin
            // Prescaler and digit stepping. sel is 3 bits wide, so adding
            // one to 7 wraps back to 0 naturally.
            if (tick) begin
                cnt_next = '0;
                sel_next = sel_reg + 3'd1;
            end else begin
                cnt_next = cnt_reg + CNT_ONE;
            end

            // Promote the parked value on the same edge that sel wraps to 0.
            if (frame_end && pending_reg) begin
                active_next  = shadow_reg;
                pending_next = 1'b0;
            end

            // xfer requires pending_reg == 0, so it cannot coincide with the
            // promotion above. A load taken in the frame-end cycle therefore
            // only fills the shadow, and it is shown from the following
            // frame end.
            if (xfer) begin
                shadow_next  = ld_data;
                pending_next = 1'b1;
            end
        end
    end

    // -----------------------------------------------------------------------
    // State registers. Reset can be applied at any time, including
    // mid-scan, and returns the display to dark with no load pending.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg   <= S_OFF;
            cnt_reg     <= '0;
            sel_reg     <= '0;
            active_reg  <= '0;
            shadow_reg  <= '0;
            pending_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            sel_reg     <= sel_next;
            active_reg  <= active_next;
            shadow_reg  <= shadow_next;
            pending_reg <= pending_next;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs
    //
    // All outputs are decoded from the same registered sel/active/state, so
    // sel, num and blank always describe the same digit in the same cycle.
    // -----------------------------------------------------------------------
    logic lz_hit;

    // Digit 0 is never treated as a leading zero, so a value of 0 shows a
    // single "0" instead of a fully dark display.
    assign lz_hit = lz_blank && (sel_reg != 3'd0) && upper_zero[sel_reg];

    assign sel        = sel_reg;
    assign num        = nibble[sel_reg];
    assign blank      = (state_reg == S_OFF) || !digit_en[sel_reg] || lz_hit;
    assign frame_done = frame_end;

endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// ---------------------------------------------------------------------------
// tb_seg7_scan_ctrl
//
// Directed testbench for seg7_scan_ctrl with REFRESH_DIV = 4, which gives
// 32 cycles per frame. Inputs are driven and outputs are sampled 1 time
// unit after each rising edge. 'phase' counts the cycles since scanning
// started, so the expected digit index is (phase / 4) % 8 and the frame
// ends when phase % 32 == 31.
// ---------------------------------------------------------------------------
module tb_seg7_scan_ctrl;

    logic        clk;
    logic        rst_n;
    logic        ld_valid;
    logic [31:0] ld_data;
    logic        ld_ready;
    logic [7:0]  digit_en;
    logic        lz_blank;
    logic [2:0]  sel;
    logic [3:0]  num;
    logic        blank;
    logic        frame_done;

    int total;
    int bad;
    int phase;

    seg7_scan_ctrl #(
        .REFRESH_DIV(4)
    ) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .ld_valid   (ld_valid),
        .ld_data    (ld_data),
        .ld_ready   (ld_ready),
        .digit_en   (digit_en),
        .lz_blank   (lz_blank),
        .sel        (sel),
        .num        (num),
        .blank      (blank),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Hard time limit so that the run always ends on its own.
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1, "watchdog expired");
    end

    // Advance one clock, then settle just past the edge.
    task automatic step();
        @(posedge clk);
        #1;
        phase++;
    endtask

    function automatic logic [3:0] nib(input logic [31:0] v, input int k);
        return v[4*k +: 4];
    endfunction

    // -----------------------------------------------------------------------
    task automatic test_reset();
        logic [10:0] got, exp;
        rst_n    = 1'b0;
        ld_valid = 1'b0;
        ld_data  = 32'h0;
        digit_en = 8'hFF;
        lz_blank = 1'b0;
        step();
        step();
        got = {sel, num, blank, frame_done, ld_ready, 1'b0};
        exp = {3'd0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0};
        total++;
        if (got !== exp) begin
            $display("FAIL reset: {sel,num,blank,fd,rdy}=%b required %b", got, exp);
            bad++;
        end
        rst_n = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            got = {sel, num, blank, frame_done, ld_ready, 1'b0};
            total++;
            if (got !== exp) begin
                $display("FAIL idle cyc=%0d: {sel,num,blank,fd,rdy}=%b required %b", i, got, exp);
                bad++;
            end
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_load_from_off();
        logic [9:0] got, exp;
        int s;
        total++;
        if (ld_ready !== 1'b1) begin
            $display("FAIL ready_off: ld_ready=%b required 1", ld_ready);
            bad++;
        end
        ld_data  = 32'h76543210;
        ld_valid = 1'b1;
        step();
        ld_valid = 1'b0;
        ld_data  = 32'h0;
        phase    = 0;
        for (int i = 0; i < 64; i++) begin
            s   = (phase / 4) % 8;
            got = {sel, num, blank, frame_done, ld_ready};
            exp = {3'(s), 4'(s), 1'b0, (phase % 32 == 31), 1'b1};
            total++;
            if (got !== exp) begin
                $display("FAIL scan phase=%0d: {sel,num,blank,fd,rdy}=%b required %b", phase, got, exp);
                bad++;
            end
            step();
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_midframe_load();
        logic [9:0] got, exp;
        int s;
        while (phase % 32 != 8) step();
        total++;
        if (ld_ready !== 1'b1) begin
            $display("FAIL ready_before_mid: ld_ready=%b required 1", ld_ready);
            bad++;
        end
        ld_data  = 32'hDEADBEEF;
        ld_valid = 1'b1;
        step();
        ld_valid = 1'b0;
        ld_data  = 32'h0BADF00D;   // free to change while not ready
        while (phase % 32 != 0) begin
            s   = (phase / 4) % 8;
            got = {sel, num, blank, frame_done, ld_ready};
            exp = {3'(s), 4'(s), 1'b0, (phase % 32 == 31), 1'b0};
            total++;
            if (got !== exp) begin
                $display("FAIL hold_old phase=%0d: {sel,num,blank,fd,rdy}=%b required %b", phase, got, exp);
                bad++;
            end
            step();
        end
        for (int i = 0; i < 32; i++) begin
            s   = (phase / 4) % 8;
            got = {sel, num, blank, frame_done, ld_ready};
            exp = {3'(s), nib(32'hDEADBEEF, s), 1'b0, (phase % 32 == 31), 1'b1};
            total++;
            if (got !== exp) begin
                $display("FAIL mid_new phase=%0d: {sel,num,blank,fd,rdy}=%b required %b", phase, got, exp);
                bad++;
            end
            step();
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_frame_end_load();
        logic [9:0] got, exp;
        int s;
        while (phase % 32 != 31) step();
        total++;
        if ({frame_done, ld_ready} !== 2'b11) begin
            $display("FAIL fe_cycle: {fd,rdy}=%b required 11", {frame_done, ld_ready});
            bad++;
        end
        ld_data  = 32'h13579BDF;
        ld_valid = 1'b1;
        step();
        ld_valid = 1'b0;
        ld_data  = 32'h0;
        // One full frame still shows the previous value.
        for (int i = 0; i < 32; i++) begin
            s   = (phase / 4) % 8;
            got = {sel, num, blank, frame_done, ld_ready};
            exp = {3'(s), nib(32'hDEADBEEF, s), 1'b0, (phase % 32 == 31), 1'b0};
            total++;
            if (got !== exp) begin
                $display("FAIL fe_hold phase=%0d: {sel,num,blank,fd,rdy}=%b required %b", phase, got, exp);
                bad++;
            end
            step();
        end
        for (int i = 0; i < 32; i++) begin
            s   = (phase / 4) % 8;
            got = {sel, num, blank, frame_done, ld_ready};
            exp = {3'(s), nib(32'h13579BDF, s), 1'b0, (phase % 32 == 31), 1'b1};
            total++;
            if (got !== exp) begin
                $display("FAIL fe_new phase=%0d: {sel,num,blank,fd,rdy}=%b required %b", phase, got, exp);
                bad++;
            end
            step();
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_lz_blank();
        logic [31:0] vals  [2] = '{32'h000000A0, 32'h00000000};
        logic [7:0]  masks [2] = '{8'hFC, 8'hFE};   // expected blank per digit
        logic [8:0]  got, exp;
        logic [7:0]  m;
        int s;
        lz_blank = 1'b1;
        for (int v = 0; v < 2; v++) begin
            ld_data  = vals[v];
            ld_valid = 1'b1;
            step();
            ld_valid = 1'b0;
            while (phase % 32 != 0) step();
            m = masks[v];
            for (int i = 0; i < 32; i++) begin
                s   = (phase / 4) % 8;
                got = {sel, num, blank, ld_ready};
                exp = {3'(s), nib(vals[v], s), m[s], 1'b1};
                total++;
                if (got !== exp) begin
                    $display("FAIL lz v=%h phase=%0d: {sel,num,blank,rdy}=%b required %b", vals[v], phase, got, exp);
                    bad++;
                end
                step();
            end
        end
        lz_blank = 1'b0;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_digit_en();
        logic [7:0] ens [2] = '{8'h0F, 8'hA5};
        logic [7:0] m;
        logic [7:0] got, exp;
        int s;
        // active is 0 here and lz_blank is off, so only digit_en darkens digits.
        for (int e = 0; e < 2; e++) begin
            m        = ens[e];
            digit_en = m;
            for (int i = 0; i < 32; i++) begin
                s   = (phase / 4) % 8;
                got = {sel, num, blank};
                exp = {3'(s), 4'h0, !m[s]};
                total++;
                if (got !== exp) begin
                    $display("FAIL digit_en en=%h phase=%0d: {sel,num,blank}=%b required %b", m, phase, got, exp);
                    bad++;
                end
                step();
            end
        end
        digit_en = 8'hFF;
    endtask

    // -----------------------------------------------------------------------
    task automatic test_reset_mid_scan();
        logic [10:0] got, exp;
        while (phase % 32 != 8) step();
        ld_data  = 32'h76543210;
        ld_valid = 1'b1;
        step();
        ld_valid = 1'b0;
        total++;
        if (ld_ready !== 1'b0) begin
            $display("FAIL pending_set: ld_ready=%b required 0", ld_ready);
            bad++;
        end
        while (phase % 32 != 20) step();
        total++;
        if (sel !== 3'd5) begin
            $display("FAIL sel5: sel=%0d required 5", sel);
            bad++;
        end
        rst_n = 1'b0;
        step();
        rst_n = 1'b1;
        exp = {3'd0, 4'h0, 1'b1, 1'b0, 1'b1, 1'b0};
        got = {sel, num, blank, frame_done, ld_ready, 1'b0};
        total++;
        if (got !== exp) begin
            $display("FAIL reset_mid: {sel,num,blank,fd,rdy}=%b required %b", got, exp);
            bad++;
        end
        for (int i = 0; i < 6; i++) begin
            step();
            got = {sel, num, blank, frame_done, ld_ready, 1'b0};
            total++;
            if (got !== exp) begin
                $display("FAIL off_hold cyc=%0d: {sel,num,blank,fd,rdy}=%b required %b", i, got, exp);
                bad++;
            end
        end
    endtask

    // -----------------------------------------------------------------------
    task automatic test_back_to_back();
        logic [9:0] got, exp;
        int s;
        ld_data  = 32'hFEDCBA98;
        ld_valid = 1'b1;
        step();
        ld_valid = 1'b0;
        phase    = 0;
        for (int i = 0; i < 40; i++) begin
            s   = (phase / 4) % 8;
            got = {sel, num, blank, frame_done, ld_ready};
            exp = {3'(s), nib(32'hFEDCBA98, s), 1'b0, (phase % 32 == 31), 1'b1};
            total++;
            if (got !== exp) begin
                $display("FAIL b2b_first phase=%0d: {sel,num,blank,fd,rdy}=%b required %b", phase, got, exp);
                bad++;
            end
            step();
        end
        // Hold ld_valid high across two loads. The second is accepted only
        // in the first cycle after the first has been promoted.
        ld_data  = 32'h11111111;
        ld_valid = 1'b1;
        step();
        ld_data  = 32'h22222222;
        while (phase % 32 != 0) begin
            s   = (phase / 4) % 8;
            got = {sel, num, blank, frame_done, ld_ready};
            exp = {3'(s), nib(32'hFEDCBA98, s), 1'b0, (phase % 32 == 31), 1'b0};
            total++;
            if (got !== exp) begin
                $display("FAIL b2b_wait phase=%0d: {sel,num,blank,fd,rdy}=%b required %b", phase, got, exp);
                bad++;
            end
            step();
        end
        total++;
        if ({num, ld_ready} !== {4'h1, 1'b1}) begin
            $display("FAIL b2b_promote: {num,rdy}=%b required %b", {num, ld_ready}, {4'h1, 1'b1});
            bad++;
        end
        step();
        ld_valid = 1'b0;
        while (phase % 32 != 0) begin
            got = {4'h0, sel == 3'(((phase / 4) % 8)), num, ld_ready};
            exp = {4'h0, 1'b1, 4'h1, 1'b0};
            total++;
            if (got !== exp) begin
                $display("FAIL b2b_second_wait phase=%0d: {selok,num,rdy}=%b required %b", phase, got, exp);
                bad++;
            end
            step();
        end
        for (int i = 0; i < 32; i++) begin
            s   = (phase / 4) % 8;
            got = {sel, num, blank, frame_done, ld_ready};
            exp = {3'(s), 4'h2, 1'b0, (phase % 32 == 31), 1'b1};
            total++;
            if (got !== exp) begin
                $display("FAIL b2b_second phase=%0d: {sel,num,blank,fd,rdy}=%b required %b", phase, got, exp);
                bad++;
            end
            step();
        end
    endtask

    // -----------------------------------------------------------------------
    initial begin
        total = 0;
        bad   = 0;
        phase = 0;
        test_reset();
        test_load_from_off();
        test_midframe_load();
        test_frame_end_load();
        test_lz_blank();
        test_digit_en();
        test_reset_mid_scan();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
